// File: rtl/user_accel_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : user_accel_irq                                               |
// | Description : OBI subordinate that debounces the ADXL345 INT pin, detects  |
// |               a configurable edge, counts events and raises a level IRQ.   |
// |               Optional timestamp register: USER_ACCEL_IRQ_TSTAMP_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package user_accel_irq_pkg;
    localparam int unsigned OBI_ID_WIDTH = 4;

    typedef struct packed {
        logic [31:0]             addr;
        logic                    we;
        logic [3:0]              be;
        logic [31:0]             wdata;
        logic [OBI_ID_WIDTH-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]             rdata;
        logic [OBI_ID_WIDTH-1:0] rid;
        logic                    err;
        logic                    r_optional;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;
endpackage

module user_accel_irq
    import user_accel_irq_pkg::*;
#(
    parameter int unsigned CntWidth = 16,
    parameter int unsigned DbWidth  = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  sbr_obi_req_t obi_req_i,
    output sbr_obi_rsp_t obi_rsp_o,
    input  logic         evt_i,
    output logic         irq_o
);

    localparam logic [2:0] OFS_CTRL   = 3'd0;
    localparam logic [2:0] OFS_DBTHR  = 3'd1;
    localparam logic [2:0] OFS_STATUS = 3'd2;
    localparam logic [2:0] OFS_COUNT  = 3'd3;
`ifdef USER_ACCEL_IRQ_TSTAMP_EN
    localparam logic [2:0] OFS_TSTAMP = 3'd4;
`endif

    typedef enum logic [0:0] {
        DB_IDLE   = 1'b0,
        DB_FILTER = 1'b1
    } db_state_t;

    db_state_t                 db_state;
    logic [2:0]                ctrl;
    logic [DbWidth-1:0]        db_thr;
    logic [DbWidth-1:0]        db_cnt;
    logic                      stable;
    logic                      stable_d;
    logic                      pending;
    logic [CntWidth-1:0]       count;
    logic                      irq_q;
    logic                      rvalid;
    logic [31:0]               rdata;
    logic [OBI_ID_WIDTH-1:0]   rid;
    logic                      err;

`ifdef USER_ACCEL_IRQ_TSTAMP_EN
    logic [31:0]               cyc_cnt;
    logic [31:0]               tstamp;
`endif

    logic                      accept;
    logic                      wr;
    logic [2:0]                ofs;
    logic [31:0]               rd_mux;
    logic                      rd_err;
    logic [31:0]               be_mask;
    logic [DbWidth-1:0]        thr_wr;
    logic                      evt_pulse;
    logic                      unused_req_bits;

    assign unused_req_bits = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0],
                               obi_req_i.a.wdata, obi_req_i.a.be};

    always_comb begin
        accept  = obi_req_i.req;
        wr      = obi_req_i.req & obi_req_i.a.we;
        ofs     = obi_req_i.a.addr[4:2];
        be_mask = {{8{obi_req_i.a.be[3]}}, {8{obi_req_i.a.be[2]}},
                   {8{obi_req_i.a.be[1]}}, {8{obi_req_i.a.be[0]}}};
        thr_wr  = (db_thr & ~be_mask[DbWidth-1:0]) |
                  (obi_req_i.a.wdata[DbWidth-1:0] & be_mask[DbWidth-1:0]);
        // A pulse is one cycle after stable flips, in the configured direction
        evt_pulse = ctrl[0] & (stable ^ stable_d) & (stable ^ ctrl[1]);
        rd_mux  = '0;
        rd_err  = 1'b0;
        case (ofs)
            OFS_CTRL:   rd_mux[2:0]          = ctrl;
            OFS_DBTHR:  rd_mux[DbWidth-1:0]  = db_thr;
            OFS_STATUS: rd_mux[1:0]          = {stable, pending};
            OFS_COUNT:  rd_mux[CntWidth-1:0] = count;
`ifdef USER_ACCEL_IRQ_TSTAMP_EN
            OFS_TSTAMP: rd_mux               = tstamp;
`endif
            default:    rd_err               = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_state <= DB_IDLE;
            ctrl     <= '0;
            db_thr   <= '0;
            db_cnt   <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            pending  <= 1'b0;
            count    <= '0;
            irq_q    <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rid      <= '0;
            err      <= 1'b0;
`ifdef USER_ACCEL_IRQ_TSTAMP_EN
            cyc_cnt  <= '0;
            tstamp   <= '0;
`endif
        end else begin
            rvalid <= accept;
            if (accept) begin
                rdata <= rd_mux;
                err   <= rd_err;
                rid   <= obi_req_i.a.aid;
            end

            if (wr && ofs == OFS_CTRL && obi_req_i.a.be[0]) begin
                ctrl <= obi_req_i.a.wdata[2:0];
            end
            if (wr && ofs == OFS_DBTHR) begin
                db_thr <= thr_wr;
            end

            // Set wins over a same-cycle W1C
            if (evt_pulse) begin
                pending <= 1'b1;
            end else if (wr && ofs == OFS_STATUS && obi_req_i.a.be[0] && obi_req_i.a.wdata[0]) begin
                pending <= 1'b0;
            end

            if (wr && ofs == OFS_COUNT) begin
                count <= evt_pulse ? CntWidth'(1) : '0;
            end else if (evt_pulse && !(&count)) begin
                count <= count + CntWidth'(1);
            end

            irq_q    <= pending & ctrl[2];
            stable_d <= stable;

            case (db_state)
                DB_IDLE: begin
                    db_cnt <= '0;
                    if (evt_i != stable) begin
                        if (db_thr == '0) begin
                            stable <= evt_i;
                        end else begin
                            db_state <= DB_FILTER;
                            db_cnt   <= DbWidth'(1);
                        end
                    end
                end
                DB_FILTER: begin
                    if (evt_i == stable) begin
                        db_state <= DB_IDLE;
                        db_cnt   <= '0;
                    end else if (db_cnt >= db_thr) begin
                        stable   <= evt_i;
                        db_state <= DB_IDLE;
                        db_cnt   <= '0;
                    end else begin
                        db_cnt <= db_cnt + DbWidth'(1);
                    end
                end
                default: begin
                    db_state <= DB_IDLE;
                    db_cnt   <= '0;
                end
            endcase

`ifdef USER_ACCEL_IRQ_TSTAMP_EN
            cyc_cnt <= cyc_cnt + 32'd1;
            if (evt_pulse) begin
                tstamp <= cyc_cnt;
            end
`endif
        end
    end

    always_comb begin
        obi_rsp_o              = '0;
        obi_rsp_o.gnt          = obi_req_i.req;
        obi_rsp_o.rvalid       = rvalid;
        obi_rsp_o.r.rdata      = rdata;
        obi_rsp_o.r.rid        = rid;
        obi_rsp_o.r.err        = err;
        obi_rsp_o.r.r_optional = 1'b0;
    end

    assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_user_accel_irq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_user_accel_irq                                            |
// | Description : Self-checking bench for user_accel_irq: directed scenarios   |
// |               plus randomized traffic against a behavioural model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_user_accel_irq;
    import user_accel_irq_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    sbr_obi_req_t req_s;
    sbr_obi_rsp_t rsp_s;
    logic         evt;
    logic         irq;
    logic         chk_en = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic [3:0]   id_ctr = 4'd0;

    user_accel_irq #(.CntWidth(CNT_W), .DbWidth(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (req_s),
        .obi_rsp_o (rsp_s),
        .evt_i     (evt),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: register file, debounce run length, response slot
    logic [2:0]  m_ctrl;
    logic [15:0] m_thr;
    logic        m_pending, m_stable, m_stable_last, m_irq;
    int          m_count, m_run;
    logic        m_rvalid, m_err;
    logic [31:0] m_rdata;
    logic [3:0]  m_rid;
    logic [31:0] m_cyc, m_tstamp;

    always @(posedge clk) begin
        logic        pulse, old_stable;
        logic [31:0] rv;
        logic        e;
        logic [2:0]  ofs;
        int          old_thr;
        if (rst) begin
            m_ctrl = 0; m_thr = 0; m_pending = 0; m_stable = 0; m_stable_last = 0;
            m_irq = 0; m_count = 0; m_run = 0; m_rvalid = 0; m_err = 0;
            m_rdata = 0; m_rid = 0; m_cyc = 0; m_tstamp = 0;
        end else begin
            ofs        = req_s.a.addr[4:2];
            old_stable = m_stable;
            old_thr    = int'(m_thr);
            pulse      = m_ctrl[0] && (m_stable != m_stable_last) && (m_stable == !m_ctrl[1]);
            rv = 32'd0;
            e  = 1'b0;
            case (ofs)
                3'd0: rv = {29'd0, m_ctrl};
                3'd1: rv = {16'd0, m_thr};
                3'd2: rv = {30'd0, m_stable, m_pending};
                3'd3: rv = 32'(m_count);
`ifdef USER_ACCEL_IRQ_TSTAMP_EN
                3'd4: rv = m_tstamp;
`endif
                default: e = 1'b1;
            endcase
            m_rvalid = req_s.req;
            if (req_s.req) begin
                m_rdata = rv;
                m_err   = e;
                m_rid   = req_s.a.aid;
            end
            m_irq = m_pending && m_ctrl[2];
            if (pulse) begin
                m_pending = 1'b1;
                if (m_count < CNT_MAX) m_count++;
`ifdef USER_ACCEL_IRQ_TSTAMP_EN
                m_tstamp = m_cyc;
`endif
            end
            if (req_s.req && req_s.a.we) begin
                case (ofs)
                    3'd0: if (req_s.a.be[0]) m_ctrl = req_s.a.wdata[2:0];
                    3'd1: for (int b = 0; b < 2; b++)
                              if (req_s.a.be[b]) m_thr[8*b +: 8] = req_s.a.wdata[8*b +: 8];
                    3'd2: if (!pulse && req_s.a.be[0] && req_s.a.wdata[0]) m_pending = 1'b0;
                    3'd3: m_count = pulse ? 1 : 0;
                    default: ;
                endcase
            end
            // stable takes evt after more than thr consecutive differing samples
            if (evt != m_stable) begin
                m_run++;
                if (m_run > old_thr) begin
                    m_stable = evt;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            m_stable_last = old_stable;
            m_cyc = m_cyc + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", {31'd0, rsp_s.gnt}, {31'd0, req_s.req});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            chk("rvalid", {31'd0, rsp_s.rvalid}, {31'd0, m_rvalid});
            if (m_rvalid && rsp_s.rvalid) begin
                chk("rdata", rsp_s.r.rdata, m_rdata);
                chk("err", {31'd0, rsp_s.r.err}, {31'd0, m_err});
                chk("rid", {28'd0, rsp_s.r.rid}, {28'd0, m_rid});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
        logic [3:0] id;
        id = id_ctr;
        id_ctr = id_ctr + 4'd1;
        req_s.req = 1'b1; req_s.a.we = w; req_s.a.addr = a;
        req_s.a.wdata = d; req_s.a.be = 4'hF; req_s.a.aid = id;
        tick();
        req_s.req = 1'b0; req_s.a.we = 1'b0;
        chk("acc_rvalid", {31'd0, rsp_s.rvalid}, 32'd1);
        chk("acc_rid", {28'd0, rsp_s.r.rid}, {28'd0, id});
        rd = rsp_s.r.rdata;
        er = rsp_s.r.err;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        er;
        access(1'b1, a, d, rd, er);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        access(1'b0, a, 32'd0, rd, er);
        chk(name, rd, exp);
        chk({name, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        rst = 1'b1; evt = 1'b0; req_s = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // T1: reset values
        chk("t1_irq", {31'd0, irq}, 32'd0);
        rd_chk("t1_ctrl", 32'h00, 32'd0, 1'b0);
        rd_chk("t1_dbthr", 32'h04, 32'd0, 1'b0);
        rd_chk("t1_status", 32'h08, 32'd0, 1'b0);
        rd_chk("t1_count", 32'h0C, 32'd0, 1'b0);
`ifdef USER_ACCEL_IRQ_TSTAMP_EN
        rd_chk("t1_tstamp", 32'h10, 32'd0, 1'b0);
`else
        rd_chk("t1_tstamp", 32'h10, 32'd0, 1'b1);
`endif

        // T2: rising edge with db_thr=0, irq three cycles later, W1C clears it
        wr(32'h00, 32'h5);
        wr(32'h04, 32'h0);
        ticks(2);
        evt = 1'b1;
        tick();
        tick();
        chk("t2_irq_early", {31'd0, irq}, 32'd0);
        tick();
        chk("t2_irq_set", {31'd0, irq}, 32'd1);
        rd_chk("t2_status", 32'h08, 32'h3, 1'b0);
        rd_chk("t2_count", 32'h0C, 32'h1, 1'b0);
        wr(32'h08, 32'h1);
        tick();
        chk("t2_irq_clr", {31'd0, irq}, 32'd0);

        // T3: debounce threshold 10 rejects a 5-cycle glitch, accepts 12 cycles
        wr(32'h04, 32'd10);
        evt = 1'b0;
        ticks(15);
        wr(32'h0C, 32'h0);
        evt = 1'b1;
        ticks(5);
        evt = 1'b0;
        ticks(15);
        rd_chk("t3_glitch", 32'h0C, 32'h0, 1'b0);
        evt = 1'b1;
        ticks(12);
        ticks(3);
        rd_chk("t3_count", 32'h0C, 32'h1, 1'b0);
        wr(32'h00, 32'h1);
        ticks(2);
        chk("t3_masked_irq", {31'd0, irq}, 32'd0);
        rd_chk("t3_pending_kept", 32'h08, 32'h3, 1'b0);

        // T4: falling edge mode counts only the fall
        wr(32'h00, 32'h0);
        wr(32'h04, 32'h0);
        evt = 1'b0;
        ticks(4);
        wr(32'h0C, 32'h0);
        wr(32'h08, 32'h1);
        wr(32'h00, 32'h3);
        evt = 1'b1;
        ticks(4);
        rd_chk("t4_rise", 32'h0C, 32'h0, 1'b0);
        evt = 1'b0;
        ticks(4);
        rd_chk("t4_fall", 32'h0C, 32'h1, 1'b0);
        rd_chk("t4_status", 32'h08, 32'h1, 1'b0);

        // T5: saturation and same-cycle collisions
        wr(32'h00, 32'h1);
        wr(32'h0C, 32'h0);
        for (int i = 0; i < 20; i++) begin
            evt = 1'b1; ticks(3);
            evt = 1'b0; ticks(3);
        end
        rd_chk("t5_sat", 32'h0C, 32'hF, 1'b0);
        wr(32'h08, 32'h1);
        rd_chk("t5_cleared", 32'h08, 32'h0, 1'b0);
        evt = 1'b1;
        tick();
        wr(32'h08, 32'h1);
        rd_chk("t5_set_wins", 32'h08, 32'h3, 1'b0);
        evt = 1'b0;
        ticks(3);
        evt = 1'b1;
        tick();
        wr(32'h0C, 32'h0);
        rd_chk("t5_cnt_one", 32'h0C, 32'h1, 1'b0);

        // T6: unmapped offsets
        rd_chk("t6_rd14", 32'h14, 32'h0, 1'b1);
        access(1'b1, 32'h18, 32'hFFFF_FFFF, rd, er);
        chk("t6_wr18_err", {31'd0, er}, 32'd1);
`ifdef USER_ACCEL_IRQ_TSTAMP_EN
        access(1'b1, 32'h10, 32'h1234, rd, er);
        chk("t6_wr10_err", {31'd0, er}, 32'd0);
`else
        rd_chk("t6_rd10", 32'h10, 32'h0, 1'b1);
`endif

        // Randomized traffic; every cycle is checked against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) evt = ~evt;
            if ($urandom_range(0, 2) == 0) begin
                req_s.req     = 1'b1;
                req_s.a.we    = $urandom_range(0, 1) == 1;
                req_s.a.addr  = {$urandom_range(0, 3), 25'd0, 3'($urandom_range(0, 7)), 2'b00};
                req_s.a.be    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                req_s.a.wdata = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 7)) : $urandom;
                req_s.a.aid   = 4'($urandom);
            end else begin
                req_s.req  = 1'b0;
                req_s.a.we = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        req_s.req = 1'b0;
        ticks(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
